// File: rtl/acc_pack_pkg.sv
// Shared state type, header layout and header builder for the accumulator frame packer.
package acc_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [63:0] SYNC_WORD_DEFAULT = 64'hA5A5_5A5A_0F0F_F0F0;

  // Header beat field LSB positions; fields above HDR_LEN_LSB+16 are packed MSB-first.
  localparam int HDR_BEAT_WD  = 512;
  localparam int HDR_SYNC_LSB = 448;
  localparam int HDR_ENC_LSB  = 384;
  localparam int HDR_SEQ_LSB  = 352;
  localparam int HDR_LEN_LSB  = 336;

  function automatic logic [HDR_BEAT_WD-1:0] build_header(
    input logic [63:0] sync_word,
    input logic [63:0] enc,
    input logic [31:0] seq,
    input logic [15:0] len
  );
    logic [HDR_BEAT_WD-1:0] beat;
    beat                      = '0;
    beat[HDR_SYNC_LSB +: 64]  = sync_word;
    beat[HDR_ENC_LSB  +: 64]  = enc;
    beat[HDR_SEQ_LSB  +: 32]  = seq;
    beat[HDR_LEN_LSB  +: 16]  = len;
    return beat;
  endfunction

endpackage

// File: rtl/acc_pack_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on rd_data whenever !empty.
module acc_pack_fifo #(
  parameter int WIDTH = 576,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; pointers alone define validity, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/acc_frame_pack.sv
// Packs the unthrottled accumulator sample stream into header + FRAME_LEN data beats on a valid/ready output.
module acc_frame_pack
  import acc_pack_pkg::*;
#(
  parameter int          DATA_WD    = 512,
  parameter int          HEAD_WD    = 64,
  parameter int          FRAME_LEN  = 256,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [63:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic               acc_ivld,
  input  logic [DATA_WD-1:0] acc_idat,
  input  logic [HEAD_WD-1:0] enc_idat,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [DATA_WD-1:0] m_tdata,
  output logic               m_tlast,
  output logic [31:0]        frame_seq,
  output logic [15:0]        ovf_cnt,
  output logic               busy
);

  localparam int          ENTRY_WD = DATA_WD + HEAD_WD;
  localparam logic [15:0] LEN_W    = 16'(FRAME_LEN);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [ENTRY_WD-1:0] fifo_dout;
  logic [HEAD_WD-1:0]  head_enc;
  logic [DATA_WD-1:0]  head_dat;

  state_e              state_q, state_d;
  logic [HEAD_WD-1:0]  hdr_enc_q, hdr_enc_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic [31:0]         frame_seq_q, frame_seq_d;
  logic [15:0]         ovf_cnt_q, ovf_cnt_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic [DATA_WD-1:0]  m_tdata_q, m_tdata_d;
  logic                slot_free, load_data;

  // Full blocks the write even when a pop happens in the same cycle.
  assign fifo_wr  = acc_ivld & cfg_en & ~fifo_full;
  assign head_enc = fifo_dout[DATA_WD +: HEAD_WD];
  assign head_dat = fifo_dout[DATA_WD-1:0];

  acc_pack_fifo #(
    .WIDTH (ENTRY_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({enc_idat, acc_idat}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (acc_ivld && cfg_en && fifo_full && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    hdr_enc_d   = hdr_enc_q;
    beat_cnt_d  = beat_cnt_q;
    frame_seq_d = frame_seq_q;
    slot_free   = ~m_tvalid_q | m_tready;
    m_tvalid_d  = m_tvalid_q & ~m_tready;
    m_tlast_d   = slot_free ? 1'b0 : m_tlast_q;
    m_tdata_d   = m_tdata_q;
    load_data   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_en && !fifo_empty) begin
          hdr_enc_d = head_enc;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        // The output slot is always empty on entry, so m_tvalid_q marks the header as loaded.
        if (!m_tvalid_q) begin
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tdata_d  = DATA_WD'(build_header(SYNC_WORD, hdr_enc_q, frame_seq_q, LEN_W));
        end else if (m_tready) begin
          state_d   = ST_DATA;
          load_data = ~fifo_empty;
        end
      end
      ST_DATA: begin
        if (m_tvalid_q && m_tready && m_tlast_q) begin
          frame_seq_d = frame_seq_q + 32'd1;
          beat_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else begin
          load_data = slot_free & ~fifo_empty & (beat_cnt_q != LEN_W);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_data) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = head_dat;
      m_tlast_d  = (beat_cnt_q == LAST_IDX);
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
    fifo_rd = load_data;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_enc_q   <= '0;
      beat_cnt_q  <= '0;
      frame_seq_q <= '0;
      ovf_cnt_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_enc_q   <= hdr_enc_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_seq_q <= frame_seq_d;
      ovf_cnt_q   <= ovf_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdata_q   <= m_tdata_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tdata   = m_tdata_q;
  assign frame_seq = frame_seq_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_acc_frame_pack.sv
// Directed and randomized bench for acc_frame_pack against a frame-level reference queue.
module tb_acc_frame_pack;

  localparam int          DW   = 512;
  localparam int          HW   = 64;
  localparam int          FL   = 4;
  localparam int          FD   = 4;
  localparam int          BW   = DW + 1;
  localparam logic [63:0] SYNC = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] ENC0 = 64'h8000_0000_0000_0010;

  logic          clk = 1'b0;
  logic          rst, cfg_en, acc_ivld, m_tready;
  logic [DW-1:0] acc_idat;
  logic [HW-1:0] enc_idat;
  logic          m_tvalid, m_tlast, busy;
  logic [DW-1:0] m_tdata;
  logic [31:0]   frame_seq;
  logic [15:0]   ovf_cnt;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0]    obs_q[$];
  logic [BW-1:0]    exp_q[$];
  logic [HW+DW-1:0] acc_q[$];
  logic [31:0]      model_seq;
  int               acc_total;
  int               hs_total;
  logic             stall_prev;
  logic [BW-1:0]    prev_beat;

  always #5 clk = ~clk;

  acc_frame_pack #(
    .DATA_WD    (DW),
    .HEAD_WD    (HW),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (FD),
    .SYNC_WORD  (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .acc_ivld  (acc_ivld),
    .acc_idat  (acc_idat),
    .enc_idat  (enc_idat),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .frame_seq (frame_seq),
    .ovf_cnt   (ovf_cnt),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [BW-1:0] observed, input logic [BW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Records handshaked beats and checks that a stalled beat is held unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_valid", BW'(m_tvalid), BW'(1));
        check("stall_beat", {m_tlast, m_tdata}, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        obs_q.push_back({m_tlast, m_tdata});
        hs_total <= hs_total + 1;
      end
      stall_prev <= m_tvalid && !m_tready;
      prev_beat  <= {m_tlast, m_tdata};
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // Frame-level model: every FL accepted samples form one header plus FL data beats.
  task automatic model_accept(input logic [HW-1:0] e, input logic [DW-1:0] d);
    acc_q.push_back({e, d});
    acc_total++;
    if (acc_q.size() == FL) begin
      exp_q.push_back({1'b0, SYNC, acc_q[0][DW +: HW], model_seq, 16'(FL), 336'd0});
      for (int i = 0; i < FL; i++) exp_q.push_back({(i == FL - 1), acc_q[i][DW-1:0]});
      acc_q.delete();
      model_seq++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [HW-1:0] e, input bit accepted);
    acc_ivld = 1'b1;
    acc_idat = d;
    enc_idat = e;
    tick();
    acc_ivld = 1'b0;
    if (accepted) model_accept(e, d);
  endtask

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit room_for_sample();
    int data_hs;
    data_hs = hs_total - (hs_total + FL) / (FL + 1);
    return (acc_total - data_hs) < FD;
  endfunction

  task automatic drain_compare(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 500) begin
      tick();
      n++;
    end
    repeat (8) tick();
    check({tag, "_count"}, BW'(obs_q.size()), BW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    end
    check({tag, "_frame_seq"}, BW'(frame_seq), BW'(model_seq));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; cfg_en = 1'b0; acc_ivld = 1'b0; m_tready = 1'b0;
    acc_idat = '0; enc_idat = '0;
    model_seq = '0; acc_total = 0; hs_total = 0;
    repeat (3) tick();
    check("rst_tvalid", BW'(m_tvalid), BW'(0));
    check("rst_tlast", BW'(m_tlast), BW'(0));
    check("rst_tdata", BW'(m_tdata), BW'(0));
    check("rst_frame_seq", BW'(frame_seq), BW'(0));
    check("rst_ovf", BW'(ovf_cnt), BW'(0));
    check("rst_busy", BW'(busy), BW'(0));
    rst = 1'b0;
    tick();

    // Single frame without stalls, including the documented output latency.
    cfg_en = 1'b1; m_tready = 1'b1;
    send(DW'(0), ENC0 + 64'd0, 1'b1);
    send(DW'(1), ENC0 + 64'd1, 1'b1);
    check("t1_lat_edge1", BW'(m_tvalid), BW'(0));
    send(DW'(2), ENC0 + 64'd2, 1'b1);
    check("t1_hdr_edge2", {m_tvalid, m_tdata}, {1'b1, SYNC, ENC0, 32'd0, 16'(FL), 336'd0});
    send(DW'(3), ENC0 + 64'd3, 1'b1);
    check("t1_data0_edge3", {m_tvalid, m_tdata}, {1'b1, DW'(0)});
    drain_compare("t1");

    // Same frame under 1010 backpressure.
    for (int i = 0; i < FL; i++) begin
      m_tready = (i % 2 == 0);
      send(DW'(i), ENC0 + 64'(i), 1'b1);
    end
    for (int k = 0; k < 30; k++) begin
      m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    drain_compare("t2");

    // Input ignored while packing is disabled.
    cfg_en = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_dat(), {$urandom(), $urandom()}, 1'b0);
    repeat (10) tick();
    check("t5_no_output", BW'(obs_q.size()), BW'(0));
    check("t5_ovf", BW'(ovf_cnt), BW'(0));
    check("t5_busy", BW'(busy), BW'(0));
    check("t5_tvalid", BW'(m_tvalid), BW'(0));
    cfg_en = 1'b1;

    // Overflow with the output stalled: only the first FD samples survive.
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(rand_dat(), {$urandom(), $urandom()}, i < FD);
    check("t3_ovf", BW'(ovf_cnt), BW'(6));
    repeat (3) tick();
    m_tready = 1'b1;
    drain_compare("t3");

    // Underflow mid-frame: the frame waits rather than being truncated.
    send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
    send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
    repeat (20) tick();
    check("t4_gap_beats", BW'(obs_q.size()), BW'(3));
    check("t4_gap_tvalid", BW'(m_tvalid), BW'(0));
    check("t4_gap_busy", BW'(busy), BW'(1));
    send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
    send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
    drain_compare("t4");

    // Random traffic and backpressure, kept below the point where samples could drop.
    for (int c = 0; c < 400; c++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if (room_for_sample() && ($urandom_range(0, 1) == 1)) send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
      else tick();
    end
    m_tready = 1'b1;
    n = 0;
    while (acc_q.size() != 0 && n < 200) begin
      if (room_for_sample()) send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
      else tick();
      n++;
    end
    drain_compare("rand");
    check("rand_ovf", BW'(ovf_cnt), BW'(6));

    // Reset after two data beats discards the partial frame.
    for (int i = 0; i < FL; i++) send(rand_dat(), {$urandom(), $urandom()}, 1'b0);
    n = 0;
    while (obs_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t6_beats_before_rst", BW'(obs_q.size()), BW'(3));
    rst = 1'b1; m_tready = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_tvalid", BW'(m_tvalid), BW'(0));
    check("t6_tlast", BW'(m_tlast), BW'(0));
    check("t6_frame_seq", BW'(frame_seq), BW'(0));
    check("t6_busy", BW'(busy), BW'(0));
    check("t6_ovf", BW'(ovf_cnt), BW'(0));
    model_seq = '0;
    acc_q.delete();
    obs_q.delete();
    exp_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < FL; i++) send(rand_dat(), {$urandom(), $urandom()}, 1'b1);
    drain_compare("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
